inst_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end that replaces the single-cycle PC/IF pair.
- Holds a fetch PC, issues one outstanding request at a time to a variable-latency instruction memory over a req/ack handshake, and buffers returned words in a DEPTH-entry FIFO.
- Presents {pc, inst} to the IF/ID register over valid/ready.
- Branch redirect from EX flushes the queue and discards any in-flight response.

---
 rtl/inst_fetch_queue.sv | 126 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction-fetch front end with one outstanding memory request and a DEPTH-entry queue
// Ports:
//   clk, rst (async, active-low)
//   mem_req_o/mem_addr_o/mem_ack_i/mem_data_i : req/ack fetch interface, data returned with ack
//   flush_i/flush_addr_i                      : branch redirect, drops queue and in-flight data
//   inst_valid_o/inst_ready_i/inst_o/pc_o     : head entry towards IF/ID
//   count_o                                   : registered queue occupancy
module inst_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [DATA_W-1:0]          mem_data_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          flush_addr_i,
  output logic                       inst_valid_o,
  input  logic                       inst_ready_i,
  output logic [DATA_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(DATA_W/8);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, mem_addr_q, mem_addr_d;
  logic mem_req_q, mem_req_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, count_nx;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DATA_W-1:0] inst_d [DEPTH];
  logic push, pop, room;
  assign inst_valid_o = (count_q != '0) && !flush_i;
  assign pop = inst_valid_o && inst_ready_i;
  assign push = (state_q == WAIT) && mem_ack_i && !flush_i;
  assign count_nx = count_q + CW'(push) - CW'(pop);
  // Occupancy after this edge; with no request left outstanding, a new one needs a free slot.
  assign room = count_nx < DEPTH_C;
  assign mem_req_o = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign inst_o = inst_q[rd_ptr_q];
  assign pc_o = pc_q[rd_ptr_q];
  assign count_o = count_q;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_nx;
    pc_d = pc_q;
    inst_d = inst_q;
    if (flush_i) begin
      count_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fetch_pc_d = flush_addr_i;
      // An in-flight request is never aborted: wait for its ack in DISCARD.
      if (state_q != IDLE) begin
        state_d = mem_ack_i ? IDLE : DISCARD;
        mem_req_d = !mem_ack_i;
      end
    end else begin
      if (push) begin
        pc_d[wr_ptr_q] = fetch_pc_q;
        inst_d[wr_ptr_q] = mem_data_i;
        wr_ptr_d = wr_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + INC;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 1'b1;
      case (state_q)
        IDLE: if (room) begin
          state_d = WAIT;
          mem_req_d = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
        WAIT: if (mem_ack_i) begin
          state_d = room ? WAIT : IDLE;
          mem_req_d = room;
          mem_addr_d = fetch_pc_q + INC;
        end
        default: if (mem_ack_i) begin
          state_d = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized bench for inst_fetch_queue against a queue-based reference model
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_req_o, mem_ack_i, flush_i, inst_valid_o, inst_ready_i;
  logic [31:0] mem_addr_o, mem_data_i, flush_addr_i, inst_o, pc_o;
  logic [2:0] count_o;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] q_pc [$];
  logic [31:0] q_inst [$];
  bit m_req, m_disc;
  logic [31:0] m_addr, m_fpc;
  always #5 clk = ~clk;
  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o), .pc_o(pc_o),
    .count_o(count_o)
  );
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_init;
    q_pc.delete();
    q_inst.delete();
    m_req = 1'b0;
    m_disc = 1'b0;
    m_addr = RPC;
    m_fpc = RPC;
  endtask
  // One cycle: called at a falling edge, checks registered outputs, drives inputs, advances the model.
  task automatic step(input bit ack, input bit ready, input bit fl, input logic [31:0] fa);
    bit pop;
    logic [31:0] data;
    check("req", {63'b0, mem_req_o}, {63'b0, m_req});
    if (m_req) check("addr", {32'b0, mem_addr_o}, {32'b0, m_addr});
    check("count", {61'b0, count_o}, 64'(q_pc.size()));
    if (q_pc.size() != 0) begin
      check("pc", {32'b0, pc_o}, {32'b0, q_pc[0]});
      check("inst", {32'b0, inst_o}, {32'b0, q_inst[0]});
    end
    ack = ack && m_req;
    data = ack ? mem_fn(m_addr) : $urandom;
    mem_ack_i = ack;
    mem_data_i = data;
    flush_i = fl;
    flush_addr_i = fa;
    inst_ready_i = ready;
    #1;
    check("valid", {63'b0, inst_valid_o}, {63'b0, (q_pc.size() != 0) && !fl});
    pop = (q_pc.size() != 0) && !fl && ready;
    if (fl) begin
      q_pc.delete();
      q_inst.delete();
      m_fpc = fa;
      if (m_req) begin
        m_req = !ack;
        m_disc = !ack;
      end
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (m_req && ack) begin
        m_req = 1'b0;
        if (m_disc) m_disc = 1'b0;
        else begin
          q_pc.push_back(m_addr);
          q_inst.push_back(data);
          m_fpc = m_fpc + 32'd4;
          if (q_pc.size() < DEPTH) begin
            m_req = 1'b1;
            m_addr = m_fpc;
          end
        end
      end else if (!m_req && q_pc.size() < DEPTH) begin
        m_req = 1'b1;
        m_addr = m_fpc;
      end
    end
    @(negedge clk);
  endtask
  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
  endfunction
  initial begin
    int lat;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    flush_i = 1'b0;
    flush_addr_i = '0;
    inst_ready_i = 1'b0;
    model_init();
    repeat (2) @(negedge clk);
    check("rst_req", {63'b0, mem_req_o}, 64'd0);
    check("rst_addr", {32'b0, mem_addr_o}, {32'b0, RPC});
    check("rst_count", {61'b0, count_o}, 64'd0);
    check("rst_valid", {63'b0, inst_valid_o}, 64'd0);
    check("rst_inst", {32'b0, inst_o}, 64'd0);
    check("rst_pc", {32'b0, pc_o}, 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, '0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      bit a;
      a = (lat == 3);
      step(a, 1'b1, 1'b0, '0);
      lat = a ? 0 : (m_req ? lat + 1 : 0);
    end
    for (int i = 0; i < 10 && !m_req; i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h100);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10 && q_pc.size() < 2; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, rnd_addr());
    for (int i = 0; i < 10 && !(m_req && !m_disc); i++) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h300);
    check("disc_req", {63'b0, mem_req_o}, 64'd1);
    flush_i = 1'b0;
    mem_ack_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_req", {63'b0, mem_req_o}, 64'd0);
    check("arst_count", {61'b0, count_o}, 64'd0);
    check("arst_valid", {63'b0, inst_valid_o}, 64'd0);
    check("arst_addr", {32'b0, mem_addr_o}, {32'b0, RPC});
    @(negedge clk);
    rst = 1'b1;
    model_init();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
